// File: rtl/qkd_pkg.sv
// Shared QKD post-processing definitions: default vector sizes and packer FSM states.
package qkd_pkg;

    localparam int unsigned QKD_N_QUBITS = 640;
    localparam int unsigned QKD_KEY_BITS = 128;

    typedef enum logic [1:0] {
        PK_IDLE = 2'b00,
        PK_SCAN = 2'b01,
        PK_DONE = 2'b10
    } pk_state_t;

endpackage : qkd_pkg

// File: rtl/sifted_key_packer.sv
// Serial compactor: walks the latched sifted vectors one qubit per clock in
// ascending order and packs the sender bits of surviving positions into a
// dense raw key, stopping as soon as the key is full.
// Optional build macro SIFTED_KEY_PARITY_EN enables the running key parity;
// without it key_parity is tied low and no parity logic exists.
module sifted_key_packer
    import qkd_pkg::*;
#(
    parameter int unsigned N_QUBITS = QKD_N_QUBITS,
    parameter int unsigned KEY_BITS = QKD_KEY_BITS,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned IDX_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_QUBITS-1:0] sifted_valid,
    input  logic [N_QUBITS-1:0] sifted_sender,
    output logic                busy,
    output logic                done,
    output logic [KEY_BITS-1:0] key,
    output logic                key_valid,
    output logic                key_short,
    output logic [CNT_W-1:0]    bit_count,
    output logic                key_parity
);

    localparam int unsigned KIDX_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    pk_state_t           state;
    logic [IDX_W-1:0]    idx;
    logic [N_QUBITS-1:0] vld_q;
    logic [N_QUBITS-1:0] snd_q;

    logic                wr_c;
    logic                bit_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [KIDX_W-1:0]   kidx_c;
    logic                full_c;
    logic                last_c;

    // Per-cycle scan decode for the currently addressed position
    always_comb begin
        wr_c      = vld_q[idx];
        bit_c     = snd_q[idx];
        cnt_inc_c = bit_count + CNT_W'(1);
        kidx_c    = KIDX_W'(bit_count);
        full_c    = wr_c && (cnt_inc_c == CNT_W'(KEY_BITS));
        last_c    = (idx == IDX_W'(N_QUBITS - 1));
    end

    // Packer FSM with registered status outputs and key datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PK_IDLE;
            idx       <= '0;
            vld_q     <= '0;
            snd_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            key_short <= 1'b0;
            bit_count <= '0;
`ifdef SIFTED_KEY_PARITY_EN
            key_parity <= 1'b0;
`endif
        end else begin
            case (state)
                PK_IDLE: begin
                    if (start) begin
                        vld_q     <= sifted_valid;
                        // Mask so undefined sender bits at dropped positions never reach the key
                        snd_q     <= sifted_sender & sifted_valid;
                        key       <= '0;
                        bit_count <= '0;
                        key_valid <= 1'b0;
                        key_short <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= PK_SCAN;
`ifdef SIFTED_KEY_PARITY_EN
                        key_parity <= 1'b0;
`endif
                    end
                end
                PK_SCAN: begin
                    if (wr_c) begin
                        key[kidx_c] <= bit_c;
                        bit_count   <= cnt_inc_c;
`ifdef SIFTED_KEY_PARITY_EN
                        key_parity  <= key_parity ^ bit_c;
`endif
                    end
                    if (full_c || last_c) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= full_c;
                        key_short <= !full_c;
                        state     <= PK_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                PK_DONE: begin
                    done  <= 1'b0;
                    state <= PK_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= PK_IDLE;
                end
            endcase
        end
    end

`ifndef SIFTED_KEY_PARITY_EN
    // Parity feature disabled: port kept, held low
    assign key_parity = 1'b0;
`endif

endmodule : sifted_key_packer

// File: tb/tb_sifted_key_packer.sv
// Randomized self-checking bench for sifted_key_packer against a queue-free
// list-walk reference of the packing rules.
module tb_sifted_key_packer;
    import qkd_pkg::*;

    localparam int unsigned NQ = QKD_N_QUBITS;
    localparam int unsigned KB = QKD_KEY_BITS;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 10;
`ifdef SIFTED_KEY_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NQ-1:0] sifted_valid = '0;
    logic [NQ-1:0] sifted_sender = '0;
    logic          busy;
    logic          done;
    logic [KB-1:0] key;
    logic          key_valid;
    logic          key_short;
    logic [CW-1:0] bit_count;
    logic          key_parity;

    int n_cmp = 0;
    int n_bad = 0;

    sifted_key_packer #(
        .N_QUBITS(NQ), .KEY_BITS(KB), .CNT_W(CW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sifted_valid(sifted_valid), .sifted_sender(sifted_sender),
        .busy(busy), .done(done), .key(key), .key_valid(key_valid),
        .key_short(key_short), .bit_count(bit_count), .key_parity(key_parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KB-1:0] got, input logic [KB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: take valid sender bits in index order until KEY_BITS are collected
    task automatic model(input logic [NQ-1:0] v, input logic [NQ-1:0] s,
                         output logic [KB-1:0] k, output int cnt, output int dcyc);
        k    = '0;
        cnt  = 0;
        dcyc = NQ + 1;
        for (int i = 0; i < NQ; i++) begin
            if (v[i]) begin
                k[cnt] = s[i];
                cnt++;
                if (cnt == KB) begin
                    dcyc = i + 2;
                    break;
                end
            end
        end
    endtask

    function automatic logic [NQ-1:0] rand_vec(input int pct);
        logic [NQ-1:0] r;
        for (int i = 0; i < NQ; i++) r[i] = ($urandom_range(99) < pct);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, KB'(busy), '0);
        check({tag, "_done"}, KB'(done), '0);
        check({tag, "_key"}, key, '0);
        check({tag, "_kvalid"}, KB'(key_valid), '0);
        check({tag, "_kshort"}, KB'(key_short), '0);
        check({tag, "_cnt"}, KB'(bit_count), '0);
        check({tag, "_par"}, KB'(key_parity), '0);
    endtask

    // Full pack transaction; optional extra start pulse at scan cycle pulse_at
    task automatic run_pack(input logic [NQ-1:0] v, input logic [NQ-1:0] s,
                            input int pulse_at, input string tag);
        logic [KB-1:0] ek;
        logic [NQ-1:0] sx;
        logic          ep;
        int            ecnt, edc, cyc;
        model(v, s, ek, ecnt, edc);
        ep = PAR_EN ? ^ek : 1'b0;
        for (int i = 0; i < NQ; i++) sx[i] = v[i] ? s[i] : 1'bx;
        @(negedge clk);
        start = 1'b1;
        sifted_valid = v;
        sifted_sender = sx;
        @(posedge clk);
        #1;
        start = 1'b0;
        sifted_valid = rand_vec(50);
        sifted_sender = rand_vec(50);
        check({tag, "_busy_go"}, KB'(busy), KB'(1));
        check({tag, "_cnt_clr"}, KB'(bit_count), '0);
        cyc = 0;
        while (done !== 1'b1 && cyc < int'(NQ) + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        check({tag, "_done_cyc"}, KB'(cyc + 1), KB'(edc));
        check({tag, "_key"}, key, ek);
        check({tag, "_cnt"}, KB'(bit_count), KB'(ecnt));
        check({tag, "_kvalid"}, KB'(key_valid), KB'(ecnt == int'(KB)));
        check({tag, "_kshort"}, KB'(key_short), KB'(ecnt != int'(KB)));
        check({tag, "_par"}, KB'(key_parity), KB'(ep));
        check({tag, "_busy_end"}, KB'(busy), '0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, KB'(done), '0);
        check({tag, "_key_hold"}, key, ek);
        check({tag, "_cnt_hold"}, KB'(bit_count), KB'(ecnt));
    endtask

    initial begin
        logic [NQ-1:0] v, s;
        int            ones;

        #1;
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All valid, alternating sender: key should be {64{2'b01}}
        v = '1;
        for (int i = 0; i < NQ; i++) s[i] = (i % 2 == 0);
        run_pack(v, s, -1, "alt");
        check("alt_pattern", key, {64{2'b01}});

        // Nothing survived sifting
        run_pack('0, rand_vec(50), -1, "empty");

        // Even indices only, sender all ones
        for (int i = 0; i < NQ; i++) v[i] = (i % 2 == 0);
        run_pack(v, '1, -1, "even");

        // 127 valid bits at the front
        v = '0;
        for (int i = 0; i < 127; i++) v[i] = 1'b1;
        run_pack(v, '1, -1, "k127");

        // 128th valid bit lands exactly on the last index
        v = '0;
        for (int i = 0; i < 127; i++) v[i] = 1'b1;
        v[NQ-1] = 1'b1;
        run_pack(v, '1, -1, "lastidx");

        // Exactly 37 ones among the first 128 valid bits
        v = '1;
        s = '0;
        ones = 0;
        while (ones < 37) begin
            int p;
            p = $urandom_range(KB - 1);
            if (!s[p]) begin
                s[p] = 1'b1;
                ones++;
            end
        end
        for (int i = KB; i < NQ; i++) s[i] = $urandom_range(1);
        run_pack(v, s, -1, "par37");

        // Start retrigger mid-scan must be ignored
        run_pack(rand_vec(40), rand_vec(50), 50, "retrig");

        // Reset mid-scan after an ignored start
        @(negedge clk);
        start = 1'b1;
        sifted_valid = '1;
        sifted_sender = rand_vec(50);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            start = (c == 50);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("mid_busy", KB'(busy), KB'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", KB'(busy), '0);
        check("post_rst_done", KB'(done), '0);
        run_pack(rand_vec(30), rand_vec(50), -1, "after_rst");

        // Random densities around the fill threshold
        for (int t = 0; t < 24; t++) begin
            int dens;
            case (t % 6)
                0: dens = 10;
                1: dens = 18;
                2: dens = 20;
                3: dens = 22;
                4: dens = 35;
                default: dens = 90;
            endcase
            run_pack(rand_vec(dens), rand_vec(50), (t % 4 == 0) ? int'($urandom_range(60, 3)) : -1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sifted_key_packer
